// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: shared types and constants for the ALU issue stage.
// Holds the func codes, field widths, instruction layout, issue-state enum
// and small func-decoding helpers.
package alu_issue_pkg;

   localparam int FUNC_W  = 4;
   localparam int REG_W   = 4;
   localparam int ADDR_W  = 8;
   localparam int INSTR_W = FUNC_W + 3 * REG_W + ADDR_W;

   localparam logic [FUNC_W-1:0] F_ADD   = 4'd0;
   localparam logic [FUNC_W-1:0] F_SUB   = 4'd1;
   localparam logic [FUNC_W-1:0] F_MUL   = 4'd2;
   localparam logic [FUNC_W-1:0] F_PASSA = 4'd3;
   localparam logic [FUNC_W-1:0] F_PASSB = 4'd4;
   localparam logic [FUNC_W-1:0] F_AND   = 4'd5;
   localparam logic [FUNC_W-1:0] F_OR    = 4'd6;
   localparam logic [FUNC_W-1:0] F_XOR   = 4'd7;
   localparam logic [FUNC_W-1:0] F_NEGA  = 4'd8;
   localparam logic [FUNC_W-1:0] F_NEGB  = 4'd9;
   localparam logic [FUNC_W-1:0] F_SHR   = 4'd10;
   localparam logic [FUNC_W-1:0] F_SHL   = 4'd11;

   typedef struct packed {
      logic [FUNC_W-1:0] func;
      logic [REG_W-1:0]  rs1;
      logic [REG_W-1:0]  rs2;
      logic [REG_W-1:0]  rd;
      logic [ADDR_W-1:0] addr;
   } instr_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_STALL
   } state_t;

   // True for funcs that read operand B, so rs2 takes part in hazard checks.
   function automatic logic uses_b(input logic [FUNC_W-1:0] f);
      case (f)
         F_ADD, F_SUB, F_MUL, F_PASSB, F_AND, F_OR, F_XOR, F_NEGB: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // True for func codes in the ALU operation set (ADD through SHL).
   function automatic logic is_legal(input logic [FUNC_W-1:0] f);
      return (f <= F_SHL);
   endfunction

endpackage

// File: rtl/alu_issue_if.sv
// alu_issue_if: valid/ready instruction channel into the issue queue.
// master drives instructions, slave (the issue stage) returns ready.
interface alu_issue_if;
   import alu_issue_pkg::*;

   logic               in_valid;
   logic               in_ready;
   logic [INSTR_W-1:0] in_instr;

   modport master (output in_valid, output in_instr, input in_ready);
   modport slave  (input in_valid, input in_instr, output in_ready);

endinterface

// File: rtl/alu_issue_fifo.sv
// alu_issue_fifo: power-of-two instruction queue with combinational head.
// Pointers wrap naturally at DEPTH; storage itself is never reset.
module alu_issue_fifo
   import alu_issue_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  instr_t                 push_data,
   input  logic                   pop,
   output instr_t                 head,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PTR_W = $clog2(DEPTH);

   instr_t           mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   assign head = mem[rd_ptr];

   // Entry storage: written on push only.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Read/write pointers and occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/alu_issue.sv
// alu_issue: in-order issue stage in front of the ALU pipeline.
// Queues instructions, stalls the head on read-after-write hazards against
// the last HAZ_WIN issued rd values, discards illegal funcs with a sticky
// error, and registers the issued fields onto the outputs.
// Optional macro ALU_ISSUE_STATS_EN adds saturating issue/stall counters.
module alu_issue
   import alu_issue_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int HAZ_WIN = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   hold,
   alu_issue_if.slave             in_if,
   output logic [FUNC_W-1:0]      func,
   output logic [REG_W-1:0]       rs1,
   output logic [REG_W-1:0]       rs2,
   output logic [REG_W-1:0]       rd,
   output logic [ADDR_W-1:0]      addr,
   output logic                   issue_valid,
   output logic                   err_illegal,
   output logic [$clog2(DEPTH):0] q_count
`ifdef ALU_ISSUE_STATS_EN
   ,
   output logic [15:0]            stat_issued,
   output logic [15:0]            stat_stall
`endif
);

   localparam int              CNT_W   = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   instr_t           push_data;
   instr_t           head;
   logic             push;
   logic             pop;
   logic             issue;
   logic             hazard;
   state_t           state;
   logic [REG_W-1:0] sb_rd  [HAZ_WIN];
   logic             sb_vld [HAZ_WIN];

   // Ready depends only on occupancy, never on a same-cycle pop.
   assign in_if.in_ready = (q_count < DEPTH_C);
   assign push_data      = instr_t'(in_if.in_instr);
   assign push           = in_if.in_valid && in_if.in_ready;

   alu_issue_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .head      (head),
      .count     (q_count)
   );

   // Head operands against every rd still in flight in the ALU pipeline.
   always_comb begin
      hazard = 1'b0;
      for (int i = 0; i < HAZ_WIN; i++) begin
         if (sb_vld[i] && ((sb_rd[i] == head.rs1) ||
                           (uses_b(head.func) && (sb_rd[i] == head.rs2)))) begin
            hazard = 1'b1;
         end
      end
   end

   // Issue state, re-evaluated every cycle from occupancy, hazard and hold.
   always_comb begin
      if (q_count == '0) begin
         state = ST_IDLE;
      end else if (hazard || hold) begin
         state = ST_STALL;
      end else begin
         state = ST_RUN;
      end
   end

   // RUN always pops; only a legal func actually issues.
   assign pop   = (state == ST_RUN);
   assign issue = pop && is_legal(head.func);

   // Scoreboard of recently issued rd values, shifted every cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < HAZ_WIN; i++) begin
            sb_vld[i] <= 1'b0;
            sb_rd[i]  <= '0;
         end
      end else begin
         for (int i = HAZ_WIN - 1; i > 0; i--) begin
            sb_vld[i] <= sb_vld[i-1];
            sb_rd[i]  <= sb_rd[i-1];
         end
         sb_vld[0] <= issue;
         sb_rd[0]  <= head.rd;
      end
   end

   // Registered issue outputs and sticky illegal-func flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         issue_valid <= 1'b0;
         err_illegal <= 1'b0;
         func        <= '0;
         rs1         <= '0;
         rs2         <= '0;
         rd          <= '0;
         addr        <= '0;
      end else begin
         issue_valid <= 1'b0;
         case (state)
            ST_RUN: begin
               if (is_legal(head.func)) begin
                  issue_valid <= 1'b1;
                  func        <= head.func;
                  rs1         <= head.rs1;
                  rs2         <= head.rs2;
                  rd          <= head.rd;
                  addr        <= head.addr;
               end else begin
                  err_illegal <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef ALU_ISSUE_STATS_EN
   // Increment that sticks at all-ones.
   function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
      return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
   endfunction

   // Issue and hazard-stall counters (stalls caused by hold are not counted).
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_issued <= '0;
         stat_stall  <= '0;
      end else begin
         stat_issued <= sat_inc(stat_issued, issue);
         stat_stall  <= sat_inc(stat_stall, (state == ST_STALL) && !hold);
      end
   end
`endif

endmodule
